// File: rtl/hkr_muldiv.sv
// HI/LO multiply/divide unit: fixed-latency multiplier, radix-2 restoring divider.
// Optional MADD/MSUB accumulate enabled by defining HKR_MULDIV_MADD_EN.
module hkr_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int DW = DATA_WIDTH;
  localparam int CNT_MAX =
    (DW - 1 > MUL_CYCLES) ? DW - 1 : MUL_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE, MUL, DIV, FIX
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic [DW-1:0]   a_q, b_q, rem;
  logic            neg_q, neg_r, b_zero;
  logic            start_mul, start_div;
  logic            wr_hi, wr_lo;
  logic            mul_fin, div_fin;
  logic            sgn, ge;
  logic [2*DW-1:0] pa, pb, prod, mul_res;
  logic [DW:0]     rem_sh, diff;
  logic [DW-1:0]   a_mag, b_mag, q_fix, r_fix;

  always_comb begin
    start_mul = 1'b0;
    start_div = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    if (op_valid && !busy && !flush) begin
      unique case (op)
        3'd0, 3'd1: start_mul = 1'b1;
        3'd2, 3'd3: start_div = 1'b1;
        3'd4:       wr_hi     = 1'b1;
        3'd5:       wr_lo     = 1'b1;
`ifdef HKR_MULDIV_MADD_EN
        3'd6, 3'd7: start_mul = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_mul)      state_nx = MUL;
        else if (start_div) state_nx = DIV;
      end
      MUL: if (cnt == '0) state_nx = IDLE;
      DIV: if (cnt == '0) state_nx = FIX;
      FIX: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_comb begin
    busy    = (state != IDLE);
    mul_fin = (state == MUL) && (cnt == '0) && !flush;
    div_fin = (state == FIX) && !flush;
  end

  // Sign-extend to 2*DW so one unsigned multiply serves both signednesses
  assign sgn  = (op_q != 3'd1);
  assign pa   = {{DW{sgn & a_q[DW-1]}}, a_q};
  assign pb   = {{DW{sgn & b_q[DW-1]}}, b_q};
  assign prod = pa * pb;

  always_comb begin
    mul_res = prod;
`ifdef HKR_MULDIV_MADD_EN
    if (op_q == 3'd6)      mul_res = {hi, lo} + prod;
    else if (op_q == 3'd7) mul_res = {hi, lo} - prod;
`endif
  end

  assign rem_sh = {rem, a_q[DW-1]};
  assign diff   = rem_sh - {1'b0, b_q};
  assign ge     = !diff[DW];

  assign a_mag = (op == 3'd2 && op_a[DW-1]) ? -op_a : op_a;
  assign b_mag = (op == 3'd2 && op_b[DW-1]) ? -op_b : op_b;
  assign q_fix = neg_q ? -a_q : a_q;
  assign r_fix = neg_r ? -rem : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rem    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      done <= mul_fin | div_fin;
      if (start_mul) begin
        op_q <= op;
        a_q  <= op_a;
        b_q  <= op_b;
`ifdef HKR_MULDIV_MADD_EN
        cnt  <= op[2] ? CW'(MUL_CYCLES) : CW'(MUL_CYCLES - 1);
`else
        cnt  <= CW'(MUL_CYCLES - 1);
`endif
      end else if (start_div) begin
        op_q   <= op;
        a_q    <= a_mag;
        b_q    <= b_mag;
        rem    <= '0;
        cnt    <= CW'(DW - 1);
        neg_q  <= (op == 3'd2) && (op_a[DW-1] ^ op_b[DW-1]);
        neg_r  <= (op == 3'd2) && op_a[DW-1];
        b_zero <= (op_b == '0);
      end else begin
        if (busy && cnt != '0) cnt <= cnt - CW'(1);
        if (state == DIV) begin
          a_q <= {a_q[DW-2:0], ge};
          rem <= ge ? diff[DW-1:0] : rem_sh[DW-1:0];
        end
      end
      if (wr_hi) hi <= op_a;
      if (wr_lo) lo <= op_a;
      if (mul_fin) {hi, lo} <= mul_res;
      if (div_fin) begin
        hi <= r_fix;
        lo <= b_zero ? '1 : q_fix;
      end
    end
  end

endmodule

// File: tb/tb_hkr_muldiv.sv
// Directed self-checking bench for hkr_muldiv.
// MADD/MSUB vectors run when HKR_MULDIV_MADD_EN is defined.
module tb_hkr_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc, dns, ovl;

  always #5 clk = ~clk;

  hkr_muldiv #(.DATA_WIDTH(32), .MUL_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid),
    .op(op), .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    op = o; op_a = a; op_b = b; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    op_a = 32'hDEAD_BEEF;
    op_b = 32'h1357_9BDF;
  endtask

  task automatic run(input logic [2:0] o,
                     input logic [31:0] a,
                     input logic [31:0] b);
    issue(o, a, b);
    cyc = 0; dns = 0; ovl = 0;
    repeat (45) begin
      @(negedge clk);
      if (busy) cyc++;
      if (done) dns++;
      if (busy && done) ovl++;
    end
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op = '0;
    op_a = '0; op_b = '0; flush = 1'b0;
    #12 rst_n = 1'b1;
    @(negedge clk);
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_busy", {busy, done}, 2'b00);

    run(3'd0, 32'hFFFF_FFFF, 32'h2);
    check("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    check("mult_cyc", cyc, 2);
    check("mult_done", dns, 1);
    check("mult_ovl", ovl, 0);

    run(3'd1, 32'hFFFF_FFFF, 32'h2);
    check("multu_res", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    check("multu_cyc", cyc, 2);

    run(3'd2, -32'sd7, 32'd2);
    check("div_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_cyc", cyc, 33);
    check("div_done", dns, 1);
    check("div_ovl", ovl, 0);

    run(3'd2, 32'd7, -32'sd2);
    check("div_neg_b", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

    run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

    run(3'd3, 32'd100, 32'd7);
    check("divu_res", {hi, lo}, 64'h0000_0002_0000_000E);

    issue(3'd3, 32'h1234, 32'h0);
    op = 3'd4; op_a = 32'hA; op_valid = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 60) begin
      cyc++;
      @(negedge clk);
    end
    check("dz_bound", cyc < 60, 1'b1);
    check("dz_res", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    check("dz_done", done, 1'b1);
    @(posedge clk);
    #1 op_valid = 1'b0;
    check("mthi_retry", hi, 32'hA);
    check("mthi_busy", {busy, done}, 2'b00);

    issue(3'd5, 32'h55, 32'h0);
    check("mtlo", lo, 32'h55);
    check("mtlo_busy", {busy, done}, 2'b00);

    issue(3'd2, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    dns = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dns++;
    end
    check("flush_hilo", {hi, lo}, 64'h0000_000A_0000_0055);
    check("flush_done", dns, 0);

    op = 3'd0; op_a = 32'h3; op_b = 32'h3;
    op_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0; flush = 1'b0;
    check("flush_drop", busy, 1'b0);
    repeat (4) @(negedge clk);
    check("flush_drop_hl", {hi, lo}, 64'h0000_000A_0000_0055);

`ifdef HKR_MULDIV_MADD_EN
    issue(3'd4, 32'h0, 32'h0);
    issue(3'd5, 32'h5, 32'h0);
    run(3'd6, 32'd3, 32'd4);
    check("madd_res", {hi, lo}, 64'd17);
    check("madd_cyc", cyc, 3);
    run(3'd7, 32'd1, 32'd18);
    check("msub_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    issue(3'd5, 32'h5, 32'h0);
    run(3'd6, 32'd3, 32'd4);
    check("op6_nop", {hi, lo}, 64'h0000_000A_0000_0005);
    check("op6_cyc", cyc, 0);
    check("op6_done", dns, 0);
`endif

    issue(3'd2, 32'd50, 32'd5);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #2;
    check("rst_mid", {hi, lo}, 64'h0);
    check("rst_mid_busy", {busy, done}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_after", {hi, lo, 30'h0, busy, done}, 96'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
